// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing and pixel address generator
// Sync and blanking are delayed so they line up with the decoder's pixel values.
module vga_timing_gen #(
    parameter int H_VISIBLE       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_VISIBLE       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int X_BITS          = 10,
    parameter int Y_BITS          = 10,
    parameter int CLK_DIV         = 1,
    parameter int PIPE_DEPTH      = 0,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              pixel_tick,
    output logic [X_BITS-1:0] pixel_x_target_next,
    output logic [Y_BITS-1:0] pixel_y_target_next,
    input  logic              pixel_value_next_R,
    input  logic              pixel_value_next_G,
    input  logic              pixel_value_next_B,
    output logic              vga_r,
    output logic              vga_g,
    output logic              vga_b,
    output logic              h_sync,
    output logic              v_sync,
    output logic              frame_start,
    output logic [15:0]       frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [X_BITS-1:0] H_LAST   = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] H_VIS    = X_BITS'(H_VISIBLE);
    localparam logic [X_BITS-1:0] HS_START = X_BITS'(H_VISIBLE + H_FRONT);
    localparam logic [X_BITS-1:0] HS_END   = X_BITS'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_BITS-1:0] V_LAST   = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] V_VIS    = Y_BITS'(V_VISIBLE);
    localparam logic [Y_BITS-1:0] VS_START = Y_BITS'(V_VISIBLE + V_FRONT);
    localparam logic [Y_BITS-1:0] VS_END   = Y_BITS'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [3:0]        DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic              SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

    logic [3:0]        r_div;
    logic [X_BITS-1:0] r_h;
    logic [Y_BITS-1:0] r_v;
    logic              r_vga_r;
    logic              r_vga_g;
    logic              r_vga_b;
    logic              r_h_sync;
    logic              r_v_sync;
    logic              r_frame_start;
    logic [15:0]       r_frame_count;

    logic              w_tick;
    logic              w_h_last;
    logic              w_wrap;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic [2:0]        w_flags_dly;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_last = (r_h == H_LAST);
    assign w_wrap   = w_h_last && (r_v == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign w_active = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs     = (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs     = (r_v >= VS_START) && (r_v < VS_END);

    // {active, hs, vs} held back by the decoder's latency so all three meet its pixel
    generate
        if (PIPE_DEPTH == 0) begin : g_no_pipe
            assign w_flags_dly = {w_active, w_hs, w_vs};
        end else begin : g_pipe
            logic [2:0] r_pipe [PIPE_DEPTH];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DEPTH; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (w_tick) begin
                    r_pipe[0] <= {w_active, w_hs, w_vs};
                    for (int i = 1; i < PIPE_DEPTH; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign w_flags_dly = r_pipe[PIPE_DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_r  <= 1'b0;
            r_vga_g  <= 1'b0;
            r_vga_b  <= 1'b0;
            r_h_sync <= SYNC_IDLE;
            r_v_sync <= SYNC_IDLE;
        end else if (w_tick) begin
            r_vga_r  <= w_flags_dly[2] & pixel_value_next_R;
            r_vga_g  <= w_flags_dly[2] & pixel_value_next_G;
            r_vga_b  <= w_flags_dly[2] & pixel_value_next_B;
            r_h_sync <= w_flags_dly[1] ^ SYNC_IDLE;
            r_v_sync <= w_flags_dly[0] ^ SYNC_IDLE;
        end
    end

    // The wrap out of reset is not a real frame boundary, so only counter wraps pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_start <= w_tick && w_wrap;
            if (w_tick && w_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign pixel_tick          = w_tick;
    assign pixel_x_target_next = r_h;
    assign pixel_y_target_next = r_v;
    assign vga_r               = r_vga_r;
    assign vga_g               = r_vga_g;
    assign vga_b               = r_vga_b;
    assign h_sync              = r_h_sync;
    assign v_sync              = r_v_sync;
    assign frame_start         = r_frame_start;
    assign frame_count         = r_frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
// Full horizontal timing with a shortened frame height keeps multi-frame runs short.
module tb_vga_timing_gen;
    localparam int VV    = 4;
    localparam int VF    = 1;
    localparam int VSW   = 2;
    localparam int VB    = 1;
    localparam int V_TOT = VV + VF + VSW + VB;
    localparam int H_TOT = 800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_tick, a_r, a_g, a_b, a_hs, a_vs, a_fs;
    logic [9:0] a_x, a_y;
    logic [15:0] a_fc;
    logic       a_ri = 1'b0, a_gi = 1'b0, a_bi = 1'b0;

    logic       b_tick, b_r, b_g, b_b, b_hs, b_vs, b_fs;
    logic [9:0] b_x, b_y;
    logic [15:0] b_fc;
    logic       b_ri = 1'b1, b_gi = 1'b0, b_bi = 1'b1;

    vga_timing_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(1), .PIPE_DEPTH(2)
    ) u_dut_a (
        .clk(clk), .reset(rst), .pixel_tick(a_tick),
        .pixel_x_target_next(a_x), .pixel_y_target_next(a_y),
        .pixel_value_next_R(a_ri), .pixel_value_next_G(a_gi), .pixel_value_next_B(a_bi),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .h_sync(a_hs), .v_sync(a_vs),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    vga_timing_gen #(
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .CLK_DIV(4), .PIPE_DEPTH(0)
    ) u_dut_b (
        .clk(clk), .reset(rst), .pixel_tick(b_tick),
        .pixel_x_target_next(b_x), .pixel_y_target_next(b_y),
        .pixel_value_next_R(b_ri), .pixel_value_next_G(b_gi), .pixel_value_next_B(b_bi),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .h_sync(b_hs), .v_sync(b_vs),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    logic [4:0] sb_q[$];
    int         mh, mv, fc_exp, a_cyc, hs_run, vs_run, hs_fall_cyc;
    logic       fs_exp, hs_prev;
    logic [2:0] dec_h1, dec_h2;
    bit         b_done = 0;

    function automatic logic [4:0] expected_pins(input int h, input int v);
        logic act, hs, vs;
        logic [4:0] e;
        act  = (h < 640) && (v < VV);
        hs   = (h >= 656) && (h < 752);
        vs   = (v >= VV + VF) && (v < VV + VF + VSW);
        e[4] = act & h[0];
        e[3] = act & h[1];
        e[2] = act & v[0];
        e[1] = ~hs;
        e[0] = ~vs;
        return e;
    endfunction

    task automatic a_restart();
        mh = 0; mv = 0; fc_exp = 0; fs_exp = 1'b0;
        hs_run = 0; vs_run = 0; hs_fall_cyc = -1; hs_prev = 1'b1;
        dec_h1 = '0; dec_h2 = '0;
        {a_ri, a_gi, a_bi} = 3'b000;
        sb_q.delete();
        repeat (3) sb_q.push_back(5'b00011);
    endtask

    task automatic a_step();
        logic [4:0] exp_pins;
        check_eq("a_tick", a_tick, 1);
        check_eq("a_x", a_x, mh);
        check_eq("a_y", a_y, mv);
        check_eq("a_frame_start", a_fs, fs_exp);
        check_eq("a_frame_count", a_fc, fc_exp);
        sb_q.push_back(expected_pins(mh, mv));
        exp_pins = sb_q.pop_front();
        check_eq("a_pins_rgb_hs_vs", {a_r, a_g, a_b, a_hs, a_vs}, exp_pins);

        // decoder stand-in: answers the address it was shown two ticks ago
        {a_ri, a_gi, a_bi} = dec_h2;
        dec_h2 = dec_h1;
        dec_h1 = {a_x[0], a_x[1], a_y[0]};

        if (!a_hs && hs_prev) begin
            check_eq("hsync_fall_addr", a_x, 659);
            if (hs_fall_cyc >= 0) check_eq("line_period", a_cyc - hs_fall_cyc, 800);
            hs_fall_cyc = a_cyc;
        end
        hs_prev = a_hs;
        if (!a_hs) hs_run++;
        else if (hs_run != 0) begin
            check_eq("hsync_width", hs_run, 96);
            hs_run = 0;
        end
        if (!a_vs) vs_run++;
        else if (vs_run != 0) begin
            check_eq("vsync_width", vs_run, VSW * H_TOT);
            vs_run = 0;
        end
        a_cyc++;

        fs_exp = (mh == H_TOT - 1) && (mv == V_TOT - 1);
        if (fs_exp) fc_exp++;
        if (mh == H_TOT - 1) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
            mh++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_a_rgb"}, {a_r, a_g, a_b}, 0);
        check_eq({tag, "_a_sync"}, {a_hs, a_vs}, 2'b11);
        check_eq({tag, "_a_fc"}, a_fc, 0);
        check_eq({tag, "_a_fs"}, a_fs, 0);
        check_eq({tag, "_a_xy"}, {a_x, a_y}, 0);
        check_eq({tag, "_a_tick"}, a_tick, 1);
        check_eq({tag, "_b_rgb"}, {b_r, b_g, b_b}, 0);
        check_eq({tag, "_b_sync"}, {b_hs, b_vs}, 2'b11);
        check_eq({tag, "_b_fc"}, b_fc, 0);
        check_eq({tag, "_b_xy"}, {b_x, b_y}, 0);
        check_eq({tag, "_b_tick"}, b_tick, 0);
    endtask

    initial begin
        a_cyc = 0;
        a_restart();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst = 1'b0;
        a_restart();
        for (int k = 0; k < 3 * H_TOT * V_TOT + 50; k++) begin
            a_step();
            @(posedge clk);
            #1;
        end
        check_eq("a_frames_after_3", a_fc, 3);

        for (int k = 0; k < H_TOT * V_TOT && !(mh == 300 && mv == 3); k++) begin
            a_step();
            @(posedge clk);
            #1;
        end
        check_eq("a_midframe_xy", {a_x, a_y}, {10'd300, 10'd3});
        check_eq("a_midframe_r", a_r, expected_pins(297, 3) >> 4);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        a_restart();
        for (int k = 0; k < 2 * H_TOT + 10; k++) begin
            a_step();
            @(posedge clk);
            #1;
        end

        for (int k = 0; k < 100 && !b_done; k++) @(posedge clk);
        check_eq("b_finished", b_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Divided instance: one tick per four clks, registered outputs one tick behind the address.
    initial begin
        int run;
        int n;
        logic exp_hs_pin, exp_r;
        run = 0;
        @(negedge rst);
        for (int c = 0; c < 3200; c++) begin
            check_eq("b_tick", b_tick, (c % 4) == 3);
            check_eq("b_x", b_x, c / 4);
            check_eq("b_y", b_y, 0);
            n = c / 4 - 1;
            exp_hs_pin = !(n >= 656 && n < 752);
            exp_r = (n >= 0 && n < 640);
            check_eq("b_hsync", b_hs, exp_hs_pin);
            check_eq("b_rgb", {b_r, b_g, b_b}, {exp_r, 1'b0, exp_r});
            if (!b_hs) run++;
            else if (run != 0) begin
                check_eq("b_hsync_clks", run, 384);
                run = 0;
            end
            @(posedge clk);
            #1;
        end
        b_done = 1;
    end
endmodule
